proj_to_affine: RTL and testbench
=================================

# proj_to_affine

Converts a projective point (X, Y, Z) over GF(p), p = 2^255 − 19, into affine coordinates x = X·Z⁻¹ mod p, y = Y·Z⁻¹ mod p. It consumes the o_x/o_y/o_z/o_finished result of ScalarMul and is the final stage before the result leaves the core. It uses one binary extended-Euclid inverter, followed by one serial modular multiplier that is used twice.

## Interface
- P_WIDTH, 255: coordinate width in bits.
- P_MOD, 255'h7fff…ffed (2^255 − 19): field modulus.
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle request; sampled only in IDLE.
- i_x, i_y, i_z  in  255 each  projective coordinates; captured on the accepted i_start.
- o_x, o_y  out  255 each  affine result; held until the next accepted i_start.
- o_finished  out  1  one-cycle pulse when o_x/o_y/o_error are valid.
- o_error  out  1  high with o_finished when Z ≡ 0; held like o_x/o_y.
- o_busy  out  1  high from the accept cycle through the o_finished cycle.

## Operation
- FSM states: IDLE → LOAD → INV → MULX → MULY → DONE → IDLE.
- **IDLE**
  - i_start=1 captures X, Y, Z and goes to LOAD.
  - i_start in any other state is ignored; no queueing.
- **LOAD**
  - Each coordinate ≥ p is reduced by one subtraction of p (inputs < 2^255 < 2p).
  - If reduced Z = 0: go to DONE with o_error=1, o_x=o_y=0.
  - Otherwise initialise u=Z, v=p, x1=1, x2=0.
- **INV**: exactly one action per cycle, in this priority order.
  - u=1 or v=1: inverse = x1 if u=1 else x2; go to MULX.
  - u even: u>>=1; x1 = x1/2 if x1 even, else (x1+p)/2. Use a 256-bit intermediate.
  - v even: same rule on v, x2.
  - u ≥ v: u −= v; x1 = x1 − x2 mod p (add p on borrow).
  - Else: v −= u; x2 = x2 − x1 mod p.
  - x1, x2 stay in [0, p) at all times.
- **MULX**: x = X·inv mod p using sub-module mod_mul; result latched into the x register.
- **MULY**: y = Y·inv mod p using the same instance.
- **DONE**: drive o_x, o_y, o_error; pulse o_finished; return to IDLE.

## Timing
- Reset values:
  - FSM = IDLE.
  - o_x = o_y = 0.
  - o_finished = o_error = o_busy = 0.
  - All internal registers = 0.
- Reset asserted mid-operation aborts immediately. No o_finished is produced. After release the block is in IDLE.
- Latency from the accept edge to the o_finished cycle: 1 (LOAD) + N_inv + 2·256 + 1.
  - N_inv ≤ 1020 for any Z in [1, p).
  - Z = 0 case: latency is 2 cycles.
- mod_mul latency: 256 cycles from its start to its done.
  - 1 load cycle, then 255 MSB-first iterations.
  - Each iteration: acc = 2·acc + (b_i ? a : 0), then conditional subtraction of p up to twice (intermediate < 3p, 257-bit).
- o_finished is high for exactly one cycle.
- o_busy falls the cycle after o_finished.
- i_start may be high in the same cycle o_busy falls; it is accepted back-to-back.

## Structure
- Package ec_pkg holds:
  - P_WIDTH and P_MOD;
  - the FSM state enum typedef;
  - the shared coordinate type `logic [254:0]`, used by ScalarMul and this block.
- Sub-module mod_mul:
  - ports: i_clk, i_rst_n, i_start, i_a, i_b, o_p, o_done;
  - serial interleaved modular multiplier, reusable by other field stages.
- The inverter stays inline in proj_to_affine.

## Test plan
- X=5, Y=7, Z=1 → o_x=5, o_y=7, o_error=0, single o_finished pulse.
- X=2, Y=4, Z=2 → o_x=1, o_y=2.
- X=3, Y=1, Z=p−1 → o_x=p−3, o_y=p−1.
- Z=0 → o_error=1, o_x=o_y=0, o_finished two cycles after accept.
- X=p+5, Y=p+7, Z=p+1 → identical to the first case (input reduction).
- ScalarMul vector:
  - stimulus: X=2f8a66a8…0125, Y=45a22939…00a2, Z=52310c49…7189;
  - check against the bench reference model: o_x·Z ≡ X and o_y·Z ≡ Y mod p;
  - i_start pulsed again mid-INV is ignored;
  - a second run in which i_rst_n is pulled low mid-MULX returns to IDLE with all outputs 0 and no o_finished.

Source files
------------

// File: rtl/ec_pkg.sv
// ec_pkg
// Shared definitions for the elliptic-curve field stages over GF(p),
// p = 2^255 - 19:
//   P_WIDTH / P_MOD : coordinate width and field modulus
//   coord_t         : one field element / projective coordinate
//   state_t         : state encoding of the projective-to-affine converter
//   reduceOnce, halfMod, subMod : small combinational GF(p) helpers
package ec_pkg;

  localparam int P_WIDTH = 255;

  // 2^255 - 19: all ones except the low five bits, which are 01101
  localparam logic [P_WIDTH-1:0] P_MOD = {{(P_WIDTH-5){1'b1}}, 5'b01101};

  // (p + 1) / 2, the amount added when halving an odd residue
  localparam logic [P_WIDTH-1:0] P_HALF_UP = (P_MOD >> 1) + 1'b1;

  typedef logic [P_WIDTH-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    INV,
    MULX,
    MULY,
    DONE
  } state_t;

  // Bring a value in [0, 2p) into [0, p) with a single subtraction
  function automatic coord_t reduceOnce(input coord_t a);
    coord_t r;
    if (a >= P_MOD) r = a - P_MOD;
    else            r = a;
    return r;
  endfunction

  // a / 2 mod p for a in [0, p). For odd a this is (a + p) / 2, written as
  // (a >> 1) + (p + 1) / 2 so the intermediate sum always fits in 255 bits.
  function automatic coord_t halfMod(input coord_t a);
    coord_t r;
    if (a[0]) r = (a >> 1) + P_HALF_UP;
    else      r = a >> 1;
    return r;
  endfunction

  // (a - b) mod p for a, b in [0, p); the extra top bit flags the borrow
  function automatic coord_t subMod(input coord_t a, input coord_t b);
    logic [P_WIDTH:0] d;
    coord_t           r;
    d = {1'b0, a} - {1'b0, b};
    if (d[P_WIDTH]) r = d[P_WIDTH-1:0] + P_MOD;
    else            r = d[P_WIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/mod_mul.sv
// mod_mul
// Serial interleaved modular multiplier, o_p = i_a * i_b mod p.
// Operands must already lie in [0, p). One cycle loads the operands, then
// 255 MSB-first iterations follow, so o_done pulses 256 cycles after the
// cycle in which i_start is high. o_p holds the last product until the next
// start. A start while a product is in flight restarts the unit.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : load i_a / i_b and begin a product
//   i_a, i_b       : multiplicand and multiplier
//   o_p            : product register
//   o_done         : one-cycle pulse when o_p is valid
module mod_mul
  import ec_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [P_WIDTH-1:0] i_a,
  input  logic [P_WIDTH-1:0] i_b,
  output logic [P_WIDTH-1:0] o_p,
  output logic               o_done
);

  localparam logic [7:0]         ITERS = 8'(P_WIDTH);
  localparam logic [P_WIDTH+1:0] PEXT  = {2'b00, P_MOD};

  coord_t             a_q, a_d;
  coord_t             b_q, b_d;
  coord_t             acc_q, acc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  coord_t             addend;
  logic [P_WIDTH+1:0] sum0;
  logic [P_WIDTH+1:0] sum1;
  coord_t             accNext;

  // One Horner step: acc = 2*acc + (bit ? a : 0). With acc, a < p the sum
  // stays below 3p, so two conditional subtractions of p bring it back.
  always_comb begin
    addend  = b_q[P_WIDTH-1] ? a_q : '0;
    sum0    = {1'b0, acc_q, 1'b0} + {2'b00, addend};
    sum1    = (sum0 >= PEXT) ? sum0 - PEXT : sum0;
    accNext = (sum1 >= PEXT) ? sum1[P_WIDTH-1:0] - P_MOD : sum1[P_WIDTH-1:0];
  end

  // Operand load on start, otherwise iterate while busy; the multiplier is
  // shifted left so its next bit is always at the top.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (i_start) begin
      a_d    = i_a;
      b_d    = i_b;
      acc_d  = '0;
      cnt_d  = ITERS;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = accNext;
      b_d   = b_q << 1;
      cnt_d = cnt_q - 8'd1;
      if (cnt_q == 8'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign o_p    = acc_q;
  assign o_done = done_q;

endmodule

// File: rtl/proj_to_affine.sv
// proj_to_affine
// Converts a projective point (X, Y, Z) over GF(2^255 - 19) into affine
// coordinates x = X/Z, y = Y/Z. Z is inverted with a binary extended-Euclid
// loop, then one serial mod_mul instance computes X*inv and Y*inv in turn.
//   i_clk, i_rst_n    : clock, asynchronous active-low reset
//   i_start           : request, honoured only in IDLE
//   i_x, i_y, i_z     : projective coordinates, captured on accept
//   o_x, o_y          : affine result, held until the next accepted start
//   o_finished        : one-cycle pulse when o_x / o_y / o_error are valid
//   o_error           : Z was congruent to zero (o_x = o_y = 0)
//   o_busy            : high from LOAD through the o_finished cycle
module proj_to_affine
  import ec_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [P_WIDTH-1:0] i_x,
  input  logic [P_WIDTH-1:0] i_y,
  input  logic [P_WIDTH-1:0] i_z,
  output logic [P_WIDTH-1:0] o_x,
  output logic [P_WIDTH-1:0] o_y,
  output logic               o_finished,
  output logic               o_error,
  output logic               o_busy
);

  localparam coord_t ONE = {{(P_WIDTH-1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  coord_t xIn_q, xIn_d;
  coord_t yIn_q, yIn_d;
  coord_t u_q, u_d;
  coord_t v_q, v_d;
  coord_t x1_q, x1_d;
  coord_t x2_q, x2_d;
  coord_t resX_q, resX_d;
  coord_t resY_q, resY_d;
  logic   err_q, err_d;

  logic   uIsOne;
  logic   vIsOne;
  logic   invDone;
  coord_t zRed;
  coord_t invSel;

  logic   mulStart;
  coord_t mulA;
  coord_t mulB;
  coord_t mulP;
  logic   mulDone;

  // u_q doubles as the raw Z holding register between accept and LOAD
  assign zRed    = reduceOnce(u_q);
  assign uIsOne  = (u_q == ONE);
  assign vIsOne  = (v_q == ONE);
  assign invDone = uIsOne || vIsOne;
  assign invSel  = uIsOne ? x1_q : x2_q;

  // The X product is launched in the last INV cycle straight from the
  // inverter registers; after that x1_q holds the inverse for the Y product.
  assign mulA = (state_q == MULX) ? yIn_q : xIn_q;
  assign mulB = (state_q == INV) ? invSel : x1_q;

  mod_mul uMul (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (mulStart),
    .i_a     (mulA),
    .i_b     (mulB),
    .o_p     (mulP),
    .o_done  (mulDone)
  );

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic; a zero Z skips straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = LOAD;
      LOAD:    state_d = (zRed == '0) ? DONE : INV;
      INV:     if (invDone) state_d = MULX;
      MULX:    if (mulDone) state_d = MULY;
      MULY:    if (mulDone) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. Each multiplication is started one cycle ahead of its state
  // so MULX and MULY each last exactly the multiplier latency.
  always_comb begin
    o_finished = (state_q == DONE);
    o_busy     = (state_q != IDLE);
    mulStart   = ((state_q == INV) && invDone) || ((state_q == MULX) && mulDone);
  end

  // Datapath next-state. The inverter keeps x1*Z = u and x2*Z = v (mod p)
  // and performs one reduction step per cycle until u or v reaches 1.
  always_comb begin
    xIn_d  = xIn_q;
    yIn_d  = yIn_q;
    u_d    = u_q;
    v_d    = v_q;
    x1_d   = x1_q;
    x2_d   = x2_q;
    resX_d = resX_q;
    resY_d = resY_q;
    err_d  = err_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          xIn_d = i_x;
          yIn_d = i_y;
          u_d   = i_z;
          err_d = 1'b0;
        end
      end
      LOAD: begin
        xIn_d = reduceOnce(xIn_q);
        yIn_d = reduceOnce(yIn_q);
        if (zRed == '0) begin
          resX_d = '0;
          resY_d = '0;
          err_d  = 1'b1;
        end else begin
          u_d  = zRed;
          v_d  = P_MOD;
          x1_d = ONE;
          x2_d = '0;
        end
      end
      INV: begin
        if (invDone) begin
          if (!uIsOne) x1_d = x2_q;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = halfMod(x1_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = halfMod(x2_q);
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = subMod(x1_q, x2_q);
        end else begin
          v_d  = v_q - u_q;
          x2_d = subMod(x2_q, x1_q);
        end
      end
      MULX: begin
        if (mulDone) resX_d = mulP;
      end
      MULY: begin
        if (mulDone) resY_d = mulP;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      xIn_q  <= '0;
      yIn_q  <= '0;
      u_q    <= '0;
      v_q    <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      resX_q <= '0;
      resY_q <= '0;
      err_q  <= 1'b0;
    end else begin
      xIn_q  <= xIn_d;
      yIn_q  <= yIn_d;
      u_q    <= u_d;
      v_q    <= v_d;
      x1_q   <= x1_d;
      x2_q   <= x2_d;
      resX_q <= resX_d;
      resY_q <= resY_d;
      err_q  <= err_d;
    end
  end

  assign o_x     = resX_q;
  assign o_y     = resY_q;
  assign o_error = err_q;

endmodule

// File: tb/tb_proj_to_affine.sv
// Testbench for proj_to_affine: table of vectors driven back-to-back with
// expectations queued on a scoreboard, followed by a reset-abort sequence.
module tb_proj_to_affine;
  import ec_pkg::*;

  localparam int MAX_WAIT = 2000;
  localparam int NUM_VEC  = 7;

  localparam logic [255:0] SM_X256 = 256'h2f8a66a8_3c1d9e57_b04f62a1_9e8d7c6b_5a4f3e2d_1c0b9a88_77665544_33220125;
  localparam logic [255:0] SM_Y256 = 256'h45a22939_d18e6f07_2c4b5a69_78879695_a4b3c2d1_e0f10213_24354657_688900a2;
  localparam logic [255:0] SM_Z256 = 256'h52310c49_8e7d6c5b_4a392817_06f5e4d3_c2b1a090_8f7e6d5c_4b3a2918_07f67189;

  typedef struct {
    coord_t x;
    coord_t y;
    coord_t z;
    coord_t expX;
    coord_t expY;
    logic   expErr;
    int     expLat;
    int     pokeAt;
  } vec_t;

  logic   i_clk = 1'b0;
  logic   i_rst_n;
  logic   i_start;
  coord_t i_x;
  coord_t i_y;
  coord_t i_z;
  coord_t o_x;
  coord_t o_y;
  logic   o_finished;
  logic   o_error;
  logic   o_busy;

  int     checks = 0;
  int     passes = 0;
  vec_t   sbQ[$];
  vec_t   vecs[NUM_VEC];

  always #5 i_clk = ~i_clk;

  proj_to_affine dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_x        (i_x),
    .i_y        (i_y),
    .i_z        (i_z),
    .o_x        (o_x),
    .o_y        (o_y),
    .o_finished (o_finished),
    .o_error    (o_error),
    .o_busy     (o_busy)
  );

  // Reference field arithmetic using wide multiply and remainder
  function automatic coord_t refMul(input coord_t a, input coord_t b);
    logic [2*P_WIDTH-1:0] prod;
    prod = {{P_WIDTH{1'b0}}, a} * {{P_WIDTH{1'b0}}, b};
    return coord_t'(prod % {{P_WIDTH{1'b0}}, P_MOD});
  endfunction

  // Inverse by Fermat: z^(p-2) mod p
  function automatic coord_t refInv(input coord_t z);
    coord_t e;
    coord_t base;
    coord_t acc;
    e    = P_MOD - coord_t'(2);
    base = z;
    acc  = coord_t'(1);
    for (int i = 0; i < P_WIDTH; i++) begin
      if (e[i]) acc = refMul(acc, base);
      base = refMul(base, base);
    end
    return acc;
  endfunction

  function automatic coord_t refReduce(input coord_t a);
    return (a >= P_MOD) ? a - P_MOD : a;
  endfunction

  function automatic vec_t mkVec(input coord_t x, input coord_t y, input coord_t z,
                                 input coord_t ex, input coord_t ey, input logic err,
                                 input int lat, input int poke);
    vec_t v;
    v.x = x; v.y = y; v.z = z;
    v.expX = ex; v.expY = ey; v.expErr = err;
    v.expLat = lat; v.pokeAt = poke;
    return v;
  endfunction

  task automatic compare(input string what, input coord_t act, input coord_t exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", what, act, exp);
  endtask

  // Pops the expected record for the run that just produced o_finished and
  // checks values, latency, pulse width and the busy fall.
  task automatic checkOutput(input int tag, input int lat, input logic timedOut);
    vec_t e;
    if (sbQ.size() == 0) begin
      checks++;
      $display("[TB] FAIL run%0d scoreboard: got output, expected no pending entry", tag);
      return;
    end
    e = sbQ.pop_front();
    compare($sformatf("run%0d finish_timeout", tag), coord_t'(timedOut), coord_t'(0));
    if (!timedOut) begin
      if (e.expLat > 0)
        compare($sformatf("run%0d latency", tag), coord_t'(lat), coord_t'(e.expLat));
      compare($sformatf("run%0d o_x", tag), o_x, e.expX);
      compare($sformatf("run%0d o_y", tag), o_y, e.expY);
      compare($sformatf("run%0d o_error", tag), coord_t'(o_error), coord_t'(e.expErr));
      compare($sformatf("run%0d busy_at_finish", tag), coord_t'(o_busy), coord_t'(1));
      if (!e.expErr) begin
        compare($sformatf("run%0d x_times_z", tag), refMul(o_x, refReduce(e.z)), refReduce(e.x));
        compare($sformatf("run%0d y_times_z", tag), refMul(o_y, refReduce(e.z)), refReduce(e.y));
      end
      @(negedge i_clk);
      compare($sformatf("run%0d finished_pulse", tag), coord_t'(o_finished), coord_t'(0));
      compare($sformatf("run%0d busy_fall", tag), coord_t'(o_busy), coord_t'(0));
    end
  endtask

  // Called on a negedge with the DUT idle; raises i_start immediately so
  // consecutive calls exercise back-to-back acceptance.
  task automatic applyStimulus(input vec_t v, input int tag, output int lat);
    logic timedOut;
    sbQ.push_back(v);
    i_x     = v.x;
    i_y     = v.y;
    i_z     = v.z;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    lat     = 1;
    compare($sformatf("run%0d busy_after_accept", tag), coord_t'(o_busy), coord_t'(1));
    while (!o_finished && lat < MAX_WAIT) begin
      if (v.pokeAt != 0 && lat == v.pokeAt) begin
        i_x     = coord_t'(11);
        i_y     = coord_t'(13);
        i_z     = coord_t'(1);
        i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      @(negedge i_clk);
      lat++;
    end
    i_start  = 1'b0;
    timedOut = !o_finished;
    checkOutput(tag, lat, timedOut);
    if (v.pokeAt != 0) begin
      @(negedge i_clk);
      compare($sformatf("run%0d no_queued_start", tag), coord_t'(o_busy), coord_t'(0));
    end
  endtask

  initial begin
    int     lat;
    int     smLat;
    int     abortAt;
    logic   sawFinish;
    logic   sawBusy;
    coord_t smX;
    coord_t smY;
    coord_t smZ;
    coord_t smInv;

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_x     = '0;
    i_y     = '0;
    i_z     = '0;
    smLat   = 0;

    repeat (3) @(negedge i_clk);
    compare("reset o_x", o_x, coord_t'(0));
    compare("reset o_y", o_y, coord_t'(0));
    compare("reset o_finished", coord_t'(o_finished), coord_t'(0));
    compare("reset o_error", coord_t'(o_error), coord_t'(0));
    compare("reset o_busy", coord_t'(o_busy), coord_t'(0));
    i_rst_n = 1'b1;
    @(negedge i_clk);

    smX   = coord_t'(SM_X256);
    smY   = coord_t'(SM_Y256);
    smZ   = coord_t'(SM_Z256);
    smInv = refInv(smZ);

    vecs[0] = mkVec(coord_t'(5), coord_t'(7), coord_t'(1),
                    coord_t'(5), coord_t'(7), 1'b0, 515, 0);
    vecs[1] = mkVec(coord_t'(2), coord_t'(4), coord_t'(2),
                    coord_t'(1), coord_t'(2), 1'b0, 516, 0);
    vecs[2] = mkVec(coord_t'(3), coord_t'(1), P_MOD - coord_t'(1),
                    P_MOD - coord_t'(3), P_MOD - coord_t'(1), 1'b0, 0, 0);
    vecs[3] = mkVec(coord_t'(9), coord_t'(10), coord_t'(0),
                    coord_t'(0), coord_t'(0), 1'b1, 2, 0);
    vecs[4] = mkVec(P_MOD + coord_t'(5), P_MOD + coord_t'(7), P_MOD + coord_t'(1),
                    coord_t'(5), coord_t'(7), 1'b0, 515, 0);
    vecs[5] = mkVec(coord_t'(123), coord_t'(456), P_MOD,
                    coord_t'(0), coord_t'(0), 1'b1, 2, 0);
    vecs[6] = mkVec(smX, smY, smZ, refMul(smX, smInv), refMul(smY, smInv),
                    1'b0, 0, 10);

    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vecs[i], i, lat);
      if (i == NUM_VEC - 1) smLat = lat;
    end

    // Abort in the middle of the X multiplication of the ScalarMul vector
    abortAt = (smLat > 600 && smLat < MAX_WAIT) ? smLat - 400 : 700;
    i_x     = smX;
    i_y     = smY;
    i_z     = smZ;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (abortAt - 1) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    compare("abort o_x", o_x, coord_t'(0));
    compare("abort o_y", o_y, coord_t'(0));
    compare("abort o_error", coord_t'(o_error), coord_t'(0));
    compare("abort o_busy", coord_t'(o_busy), coord_t'(0));
    compare("abort o_finished", coord_t'(o_finished), coord_t'(0));
    @(negedge i_clk);
    i_rst_n   = 1'b1;
    sawFinish = 1'b0;
    sawBusy   = 1'b0;
    repeat (600) begin
      @(negedge i_clk);
      if (o_finished) sawFinish = 1'b1;
      if (o_busy) sawBusy = 1'b1;
    end
    compare("abort no_finished", coord_t'(sawFinish), coord_t'(0));
    compare("abort stays_idle", coord_t'(sawBusy), coord_t'(0));

    applyStimulus(vecs[0], NUM_VEC, lat);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
